lenet_sched: RTL and testbench



---
 rtl/lenet_sched.sv | 171 +++++++++++++++++
 tb/tb_lenet_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_sched.sv
// Ping-pong scheduler for the two LeNet source banks: overlaps capture of one frame with inference on the other.
// Define LENET_SCHED_TIMEOUT_EN to add an engine watchdog that abandons a RUN bank after TIMEOUT_CYC cycles.
module lenet_sched #(
  parameter int W_SEQ       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             cap_start,
  input  logic             cap_done,
  output logic             cap_bank,
  output logic             lenet_go,
  output logic             lenet_bank,
  input  logic             lenet_ready,
  input  logic [3:0]       lenet_digit,
  output logic             result_valid,
  output logic [3:0]       result_digit,
  output logic [W_SEQ-1:0] result_seq,
  output logic [15:0]      drop_cnt,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_RUN} bank_state_t;
  typedef enum logic [1:0] {ENG_IDLE, ENG_GO, ENG_RUN} eng_state_t;

  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic [W_SEQ-1:0] seq_q [2];
  logic [W_SEQ-1:0] seq_d [2];
  logic [W_SEQ-1:0] frame_cnt, frame_d, seq_diff;
  eng_state_t       eng_q, eng_d;
  logic             last_wr, last_d, cap_bank_d, lenet_bank_d;
  logic             tgt, tgt_ok, launch_bank, idle_eval;
  logic             release_bank, timeout_hit;
  logic [1:0]       drop_inc;
  logic [16:0]      drop_sum;

  assign release_bank = (eng_q == ENG_RUN) && lenet_ready;
  assign lenet_go     = (eng_q == ENG_GO);
  assign busy         = (eng_q != ENG_IDLE);
  assign drop_sum     = {1'b0, drop_cnt} + {15'd0, drop_inc};

`ifdef LENET_SCHED_TIMEOUT_EN
  // Counts from the GO cycle, so a hit in cycle GO+TIMEOUT_CYC-1 reports at GO+TIMEOUT_CYC.
  logic [31:0] run_cyc;

  always_ff @(posedge clk) begin
    if (!rstn)                  run_cyc <= '0;
    else if (eng_d == ENG_GO)   run_cyc <= '0;
    else if (eng_q != ENG_IDLE) run_cyc <= run_cyc + 32'd1;
    else                        run_cyc <= '0;
  end

  assign timeout_hit = (eng_q == ENG_RUN) && !lenet_ready && (run_cyc == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Events are applied in order (release, capture start, capture done) on a working copy of the bank states.
  always_comb begin
    bank_d       = bank_q;
    seq_d        = seq_q;
    frame_d      = frame_cnt;
    last_d       = last_wr;
    cap_bank_d   = cap_bank;
    lenet_bank_d = lenet_bank;
    eng_d        = eng_q;
    drop_inc     = 2'd0;
    tgt          = 1'b0;
    tgt_ok       = 1'b0;
    launch_bank  = 1'b0;
    idle_eval    = 1'b0;
    seq_diff     = seq_q[0] - seq_q[1];

    if (release_bank || timeout_hit) bank_d[lenet_bank] = BANK_EMPTY;
    if (timeout_hit) drop_inc = drop_inc + 2'd1;

    if (cap_start) begin
      if (bank_d[0] == BANK_FILLING) begin
        bank_d[0] = BANK_EMPTY;
        drop_inc  = drop_inc + 2'd1;
      end
      if (bank_d[1] == BANK_FILLING) begin
        bank_d[1] = BANK_EMPTY;
        drop_inc  = drop_inc + 2'd1;
      end
      tgt_ok = 1'b1;
      if (bank_d[~last_wr] == BANK_EMPTY)                          tgt = ~last_wr;
      else if (bank_d[last_wr] == BANK_EMPTY)                      tgt = last_wr;
      else if (bank_d[0] == BANK_FULL && bank_d[1] == BANK_FULL)   tgt = ~seq_diff[W_SEQ-1];
      else if (bank_d[0] == BANK_FULL)                             tgt = 1'b0;
      else if (bank_d[1] == BANK_FULL)                             tgt = 1'b1;
      else                                                         tgt_ok = 1'b0;
      if (tgt_ok) begin
        if (bank_d[tgt] == BANK_FULL) drop_inc = drop_inc + 2'd1;
        bank_d[tgt] = BANK_FILLING;
        cap_bank_d  = tgt;
        last_d      = tgt;
      end
    end

    if (cap_done) begin
      frame_d = frame_cnt + W_SEQ'(1);
      if (bank_d[0] == BANK_FILLING) begin
        bank_d[0] = BANK_FULL;
        seq_d[0]  = frame_cnt;
      end
      if (bank_d[1] == BANK_FILLING) begin
        bank_d[1] = BANK_FULL;
        seq_d[1]  = frame_cnt;
      end
    end

    unique case (eng_q)
      ENG_IDLE: idle_eval = 1'b1;
      ENG_GO:   eng_d = ENG_RUN;
      ENG_RUN:  if (release_bank || timeout_hit) idle_eval = 1'b1;
      default:  eng_d = ENG_IDLE;
    endcase

    // Launch decision sees this cycle's events, so go follows a completed fill or release by one cycle.
    if (idle_eval) begin
      eng_d = ENG_IDLE;
      if (enable && (bank_d[0] == BANK_FULL || bank_d[1] == BANK_FULL)) begin
        seq_diff = seq_d[0] - seq_d[1];
        if (bank_d[0] == BANK_FULL && bank_d[1] == BANK_FULL) launch_bank = ~seq_diff[W_SEQ-1];
        else                                                  launch_bank = (bank_d[1] == BANK_FULL);
        bank_d[launch_bank] = BANK_RUN;
        lenet_bank_d        = launch_bank;
        eng_d               = ENG_GO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bank_q[0]    <= BANK_EMPTY;
      bank_q[1]    <= BANK_EMPTY;
      seq_q[0]     <= '0;
      seq_q[1]     <= '0;
      frame_cnt    <= '0;
      last_wr      <= 1'b1;
      eng_q        <= ENG_IDLE;
      cap_bank     <= 1'b0;
      lenet_bank   <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= 4'd8;
      result_seq   <= '0;
      drop_cnt     <= 16'd0;
      timeout_err  <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      seq_q        <= seq_d;
      frame_cnt    <= frame_d;
      last_wr      <= last_d;
      eng_q        <= eng_d;
      cap_bank     <= cap_bank_d;
      lenet_bank   <= lenet_bank_d;
      result_valid <= release_bank;
      if (release_bank) begin
        result_digit <= lenet_digit;
        result_seq   <= seq_q[lenet_bank];
      end
      drop_cnt     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      timeout_err  <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_lenet_sched.sv
// Directed self-checking bench for lenet_sched; the timeout scenario adapts to LENET_SCHED_TIMEOUT_EN.
module tb_lenet_sched;

  logic       clk = 1'b0;
  logic       rstn, enable, cap_start, cap_done, lenet_ready;
  logic [3:0] lenet_digit;
  logic       cap_bank, lenet_go, lenet_bank, result_valid, busy, timeout_err;
  logic [3:0] result_digit;
  logic [7:0] result_seq;
  logic [15:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  lenet_sched #(.W_SEQ(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .cap_start(cap_start), .cap_done(cap_done),
    .cap_bank(cap_bank), .lenet_go(lenet_go), .lenet_bank(lenet_bank),
    .lenet_ready(lenet_ready), .lenet_digit(lenet_digit),
    .result_valid(result_valid), .result_digit(result_digit), .result_seq(result_seq),
    .drop_cnt(drop_cnt), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn = 1'b0; enable = 1'b1; cap_start = 1'b0; cap_done = 1'b0;
    lenet_ready = 1'b0; lenet_digit = 4'd0;
    step(); step();
    rstn = 1'b1;
  endtask

  task automatic pulse_cap(input logic s, input logic d);
    cap_start = s; cap_done = d;
    step();
    cap_start = 1'b0; cap_done = 1'b0;
  endtask

  task automatic pulse_ready(input logic [3:0] d);
    lenet_ready = 1'b1; lenet_digit = d;
    step();
    lenet_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; cap_start = 1'b0; cap_done = 1'b0;
    lenet_ready = 1'b0; lenet_digit = 4'd0;
    step(); step();
    checks++; if ({cap_bank, lenet_go, lenet_bank, result_valid, busy, timeout_err} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {cap_bank, lenet_go, lenet_bank, result_valid, busy, timeout_err}); end
    checks++; if (result_digit !== 4'd8) begin errors++; $display("FAIL reset_digit: got %0d want 8", result_digit); end
    checks++; if (result_seq !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d want 0", result_seq); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rstn = 1'b1;
  endtask

  task automatic test_single_frame();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    checks++; if (cap_bank !== 1'b0) begin errors++; $display("FAIL single_cap_bank: got %0d want 0", cap_bank); end
    repeat (99) step();
    pulse_cap(1'b0, 1'b1);
    checks++; if (lenet_go !== 1'b1 || lenet_bank !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_go: got go=%0d bank=%0d busy=%0d want 1 0 1", lenet_go, lenet_bank, busy); end
    step();
    checks++; if (lenet_go !== 1'b0) begin errors++; $display("FAIL single_go_pulse: got %0d want 0", lenet_go); end
    repeat (49) step();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0d want 0", result_valid); end
    pulse_ready(4'd3);
    checks++; if (result_valid !== 1'b1 || result_digit !== 4'd3 || result_seq !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_result: got v=%0d d=%0d s=%0d busy=%0d want 1 3 0 0", result_valid, result_digit, result_seq, busy); end
    step();
    checks++; if (result_valid !== 1'b0 || result_digit !== 4'd3) begin errors++; $display("FAIL single_valid_pulse: got v=%0d d=%0d want 0 3", result_valid, result_digit); end
  endtask

  task automatic test_overlap();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    step(); step();
    pulse_cap(1'b1, 1'b0);
    checks++; if (cap_bank !== 1'b1) begin errors++; $display("FAIL overlap_cap_bank: got %0d want 1", cap_bank); end
    step();
    pulse_cap(1'b0, 1'b1);
    checks++; if (lenet_go !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL overlap_hold: got go=%0d busy=%0d want 0 1", lenet_go, busy); end
    repeat (3) step();
    pulse_ready(4'd5);
    checks++; if (lenet_go !== 1'b1 || lenet_bank !== 1'b1) begin errors++; $display("FAIL overlap_second_go: got go=%0d bank=%0d want 1 1", lenet_go, lenet_bank); end
    checks++; if (result_valid !== 1'b1 || result_digit !== 4'd5 || result_seq !== 8'd0) begin errors++; $display("FAIL overlap_first_result: got v=%0d d=%0d s=%0d want 1 5 0", result_valid, result_digit, result_seq); end
    step(); step();
    pulse_ready(4'd7);
    checks++; if (result_digit !== 4'd7 || result_seq !== 8'd1 || busy !== 1'b0 || lenet_go !== 1'b0) begin errors++; $display("FAIL overlap_second_result: got d=%0d s=%0d busy=%0d go=%0d want 7 1 0 0", result_digit, result_seq, busy, lenet_go); end
  endtask

  task automatic test_overwrite();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    step();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    pulse_cap(1'b1, 1'b0);
    checks++; if (cap_bank !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL overwrite_target: got bank=%0d drop=%0d want 1 1", cap_bank, drop_cnt); end
    pulse_cap(1'b0, 1'b1);
    step();
    pulse_ready(4'd2);
    checks++; if (result_seq !== 8'd0 || lenet_go !== 1'b1 || lenet_bank !== 1'b1) begin errors++; $display("FAIL overwrite_first: got s=%0d go=%0d bank=%0d want 0 1 1", result_seq, lenet_go, lenet_bank); end
    step();
    pulse_ready(4'd4);
    checks++; if (result_seq !== 8'd2 || result_digit !== 4'd4 || drop_cnt !== 16'd1) begin errors++; $display("FAIL overwrite_result: got s=%0d d=%0d drop=%0d want 2 4 1", result_seq, result_digit, drop_cnt); end
  endtask

  task automatic test_abort();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    checks++; if (cap_bank !== 1'b0) begin errors++; $display("FAIL abort_first_bank: got %0d want 0", cap_bank); end
    repeat (5) step();
    pulse_cap(1'b1, 1'b0);
    checks++; if (cap_bank !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL abort_second: got bank=%0d drop=%0d want 1 1", cap_bank, drop_cnt); end
    pulse_cap(1'b0, 1'b1);
    checks++; if (lenet_go !== 1'b1 || lenet_bank !== 1'b1) begin errors++; $display("FAIL abort_go: got go=%0d bank=%0d want 1 1", lenet_go, lenet_bank); end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    step();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    step(); step();
    cap_start = 1'b1; lenet_ready = 1'b1; lenet_digit = 4'd9;
    step();
    cap_start = 1'b0; lenet_ready = 1'b0;
    checks++; if (cap_bank !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL same_cap_bank: got bank=%0d drop=%0d want 0 0", cap_bank, drop_cnt); end
    checks++; if (lenet_go !== 1'b1 || lenet_bank !== 1'b1) begin errors++; $display("FAIL same_launch: got go=%0d bank=%0d want 1 1", lenet_go, lenet_bank); end
    checks++; if (result_valid !== 1'b1 || result_seq !== 8'd0 || result_digit !== 4'd9) begin errors++; $display("FAIL same_result: got v=%0d s=%0d d=%0d want 1 0 9", result_valid, result_seq, result_digit); end
    pulse_cap(1'b0, 1'b1);
    step();
    pulse_ready(4'd1);
    checks++; if (result_seq !== 8'd1 || lenet_go !== 1'b1 || lenet_bank !== 1'b0) begin errors++; $display("FAIL same_followup: got s=%0d go=%0d bank=%0d want 1 1 0", result_seq, lenet_go, lenet_bank); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    pulse_cap(1'b1, 1'b1);
    checks++; if (cap_bank !== 1'b0 || lenet_go !== 1'b1 || lenet_bank !== 1'b0) begin errors++; $display("FAIL b2b_first: got bank=%0d go=%0d lbank=%0d want 0 1 0", cap_bank, lenet_go, lenet_bank); end
    step();
    pulse_ready(4'd6);
    checks++; if (result_seq !== 8'd0 || result_digit !== 4'd6) begin errors++; $display("FAIL b2b_first_result: got s=%0d d=%0d want 0 6", result_seq, result_digit); end
    pulse_cap(1'b1, 1'b1);
    checks++; if (cap_bank !== 1'b1 || lenet_go !== 1'b1 || lenet_bank !== 1'b1) begin errors++; $display("FAIL b2b_second: got bank=%0d go=%0d lbank=%0d want 1 1 1", cap_bank, lenet_go, lenet_bank); end
    step();
    pulse_ready(4'd2);
    checks++; if (result_seq !== 8'd1 || result_digit !== 4'd2) begin errors++; $display("FAIL b2b_second_result: got s=%0d d=%0d want 1 2", result_seq, result_digit); end
  endtask

  task automatic test_enable();
    reset_dut();
    enable = 1'b0;
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    checks++; if (lenet_go !== 1'b0) begin errors++; $display("FAIL enable_blocked: got %0d want 0", lenet_go); end
    pulse_cap(1'b1, 1'b0);
    checks++; if (cap_bank !== 1'b1) begin errors++; $display("FAIL enable_cap_bank: got %0d want 1", cap_bank); end
    pulse_cap(1'b0, 1'b1);
    step();
    checks++; if (busy !== 1'b0 || lenet_go !== 1'b0) begin errors++; $display("FAIL enable_idle: got busy=%0d go=%0d want 0 0", busy, lenet_go); end
    enable = 1'b1;
    step();
    checks++; if (lenet_go !== 1'b1 || lenet_bank !== 1'b0) begin errors++; $display("FAIL enable_oldest: got go=%0d bank=%0d want 1 0", lenet_go, lenet_bank); end
    step();
    pulse_ready(4'd0);
    checks++; if (result_seq !== 8'd0 || lenet_go !== 1'b1 || lenet_bank !== 1'b1) begin errors++; $display("FAIL enable_next: got s=%0d go=%0d bank=%0d want 0 1 1", result_seq, lenet_go, lenet_bank); end
  endtask

  task automatic test_reset_midrun();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
    repeat (3) step();
    rstn = 1'b0; lenet_ready = 1'b1; lenet_digit = 4'd2;
    step();
    rstn = 1'b1; lenet_ready = 1'b0;
    checks++; if ({cap_bank, lenet_bank, busy, result_valid} !== 4'b0 || drop_cnt !== 16'd0 || result_digit !== 4'd8) begin errors++; $display("FAIL midrun_reset: got ctl=%b drop=%0d d=%0d want 0000 0 8", {cap_bank, lenet_bank, busy, result_valid}, drop_cnt, result_digit); end
    step();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_after: got v=%0d busy=%0d want 0 0", result_valid, busy); end
  endtask

  task automatic test_timeout();
    reset_dut();
    pulse_cap(1'b1, 1'b0);
    pulse_cap(1'b0, 1'b1);
`ifdef LENET_SCHED_TIMEOUT_EN
    repeat (15) step();
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got err=%0d busy=%0d want 0 1", timeout_err, busy); end
    step();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || drop_cnt !== 16'd1) begin errors++; $display("FAIL timeout_fire: got err=%0d busy=%0d drop=%0d want 1 0 1", timeout_err, busy, drop_cnt); end
    pulse_ready(4'd5);
    checks++; if (timeout_err !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL timeout_late_ready: got err=%0d v=%0d want 0 0", timeout_err, result_valid); end
`else
    begin
      int seen = 0;
      repeat (40) begin
        step();
        if (timeout_err !== 1'b0) seen++;
      end
      checks++; if (seen !== 0 || busy !== 1'b1) begin errors++; $display("FAIL notimeout_wait: got err_cycles=%0d busy=%0d want 0 1", seen, busy); end
      pulse_ready(4'd5);
      checks++; if (result_valid !== 1'b1 || result_digit !== 4'd5) begin errors++; $display("FAIL notimeout_ready: got v=%0d d=%0d want 1 5", result_valid, result_digit); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overlap();
    test_overwrite();
    test_abort();
    test_same_cycle();
    test_back_to_back();
    test_enable();
    test_reset_midrun();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
